router_ingress_fsm: RTL
=======================

// Module: router_ingress_fsm
// PURPOSE
//  Ingress controller upstream of the per-destination router FIFOs. Parses one packet at a time
//  on a byte stream: header {len[5:0],dest[1:0]}, len payload bytes, then one parity byte.
//  Steers writes to the addressed FIFO with the lfd_state marker. Back-pressures the source via busy.
//  Computes XOR parity over header+payload and flags a mismatch with the received parity byte.
// PARAMETERS
//  DATA_W    8  byte width; header is {len[DATA_W-1:ADDR_W], dest[ADDR_W-1:0]}
//  ADDR_W    2  destination field width
//  NUM_PORTS 3  number of FIFOs; dest >= NUM_PORTS is an invalid address
// PORTS
//  clk        in   1          clock; all state changes on posedge
//  rst        in   1          synchronous, active-high reset
//  pkt_valid  in   1          high during header+payload bytes; low on the parity byte
//  data_in    in   DATA_W     byte from source; must be held stable while busy=1
//  fifo_full  in   NUM_PORTS  per-FIFO full
//  fifo_empty in   NUM_PORTS  per-FIFO empty
//  soft_rst   in   NUM_PORTS  per-FIFO soft reset (timeout flush)
//  busy       out  1          source must hold data_in/pkt_valid this cycle
//  wr_en      out  NUM_PORTS  one-hot FIFO write enable
//  lfd_state  out  1          high only on the header write cycle
//  data_out   out  DATA_W     byte to FIFO data_in
//  err        out  1          parity error of the last completed packet
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=DECODE_ADDRESS, err=0, parity acc=0, hdr reg=0. Outputs busy/wr_en/lfd_state=0, data_out=0.
//  Byte accepted = busy==0 in a consuming state. Outputs are combinational from state+inputs. err is registered.
//  DECODE_ADDRESS: busy=0. On pkt_valid: latch header, acc<=header.
//    Invalid dest -> DISCARD. fifo_empty[dest] -> LOAD_FIRST_DATA. Else -> WAIT_TILL_EMPTY.
//  WAIT_TILL_EMPTY: busy=1, no write. Moves to LOAD_FIRST_DATA on fifo_empty[dest].
//  LOAD_FIRST_DATA: busy=1, lfd_state=1, wr_en[dest]=1, data_out=header. Next state is LOAD_DATA.
//  LOAD_DATA: data_out=data_in.
//    pkt_valid & !full: write, acc^=data_in, stay.
//    pkt_valid & fifo_full[dest]: busy=1, no write -> FIFO_FULL_STATE.
//    !pkt_valid: byte is parity; write it (or go FIFO_FULL if full) -> CHECK_PARITY.
//  FIFO_FULL_STATE: busy=1, no write. Returns to LOAD_DATA when !fifo_full[dest]; the held byte is written there.
//  CHECK_PARITY: busy=1, no write. err<=(acc!=parity byte). Next state is DECODE_ADDRESS.
//  DISCARD: busy=0, no writes. Consumes bytes until the !pkt_valid byte, then DECODE_ADDRESS. err unchanged.
//  Write count per packet = len+2 (header, payload, parity), matching the FIFO's count load.
//  len=0: LOAD_FIRST_DATA then the parity byte is written directly in LOAD_DATA.
//  soft_rst[dest] while in any state except DECODE_ADDRESS/DISCARD -> DISCARD next cycle.
//    The write in that cycle is suppressed. Priority: rst > soft_rst > normal.
//  err: 0 after rst; updated only in CHECK_PARITY; held otherwise. Back-to-back packets are allowed.
// CONFIGURATION
//  `ROUTER_LEN_CHECK_EN defined: count accepted payload bytes (LEN_W counter).
//    In CHECK_PARITY, err<=parity mismatch OR count!=len.
//    Payload bytes beyond len are still written; there is no truncation.
//  Not defined: no counter; err reflects parity only.
// STRUCTURE
//  router_pkg: state enum (7 states), LEN_W=DATA_W-ADDR_W, header field slice functions, is_valid_dest().
//  Sub-module router_parity_acc: clear/load/xor-accumulate register plus compare output.
//  Everything else lives in this module.
// TESTING
//  1 Header 0x0D (len3,dest1), payload 11/22/33, parity 0x0D, fifo_empty=3'b111.
//    -> wr_en=010 for 5 cycles, lfd_state only on 0x0D, err=0.
//  2 Same packet with parity byte 0x0C -> all 5 bytes written, err=1 two cycles after the parity byte.
//    Next good packet clears err to 0.
//  3 fifo_full[1]=1 for 3 cycles mid-payload.
//    -> busy=1 those cycles, 0x22 held and written once after release, no duplicate or lost byte.
//  4 Header 0x03 (dest 3) -> DISCARD, wr_en stays 000 through the parity byte, then header 0x04 (len1,dest0) accepted.
//  5 fifo_empty[2]=0 at header 0x0A -> busy=1, no writes.
//    fifo_empty[2] rises -> header written with lfd_state=1 next cycle.
//  6 soft_rst[1] pulse during payload -> writes stop, remaining bytes discarded, FSM in DECODE_ADDRESS.
//    rst mid-packet -> all outputs 0 next cycle.
//  `ROUTER_LEN_CHECK_EN: header len2 with 3 payload bytes and correct parity -> err=1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header helpers for the router ingress path.
// Optional build macro honoured by router_ingress_fsm: ROUTER_LEN_CHECK_EN.
package router_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 2;
    localparam int DEF_NUM_PORTS = 3;
    localparam int LEN_W         = DEF_DATA_W - DEF_ADDR_W;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        CHECK_PARITY,
        DISCARD
    } state_t;

    // Field helpers take widths as arguments so they serve any parameterisation.
    function automatic int unsigned field_dest(input logic [31:0] hdr, input int unsigned addr_w);
        return hdr & ((32'd1 << addr_w) - 32'd1);
    endfunction

    function automatic int unsigned field_len(input logic [31:0] hdr, input int unsigned addr_w);
        return hdr >> addr_w;
    endfunction

    function automatic logic is_valid_dest(input int unsigned dest, input int unsigned num_ports);
        return dest < num_ports;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity register: load with the header, fold in payload bytes,
// compare against the received parity byte.
module router_parity_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] cmp_val,
    output logic              mismatch
);

    logic [DATA_W-1:0] acc_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_reg <= '0;
        end else if (load) begin
            acc_reg <= din;
        end else if (acc_en) begin
            acc_reg <= acc_reg ^ din;
        end
    end

    assign mismatch = (acc_reg != cmp_val);

endmodule

// File: rtl/router_ingress_fsm.sv
// Packet ingress parser/steering FSM feeding the per-destination FIFOs.
// Define ROUTER_LEN_CHECK_EN to also flag payload-length mismatches in err.
module router_ingress_fsm
    import router_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_rst,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] wr_en,
    output logic                 lfd_state,
    output logic [DATA_W-1:0]    data_out,
    output logic                 err
);

    localparam int CNT_W = DATA_W - ADDR_W;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] hdr_reg, hdr_next;
    logic [DATA_W-1:0] par_reg, par_next;
    logic              err_reg, err_next;

    logic [ADDR_W-1:0]    in_dest, hdr_dest;
    logic [NUM_PORTS-1:0] in_sel, hdr_sel;
    logic                 in_dest_ok, cur_empty, cur_full, soft_hit;
    logic                 acc_clear, acc_load, acc_xor, par_mismatch, len_err;
    logic                 cnt_clr, cnt_inc;

    assign in_dest    = ADDR_W'(field_dest(32'(data_in), ADDR_W));
    assign hdr_dest   = ADDR_W'(field_dest(32'(hdr_reg), ADDR_W));
    assign in_dest_ok = is_valid_dest(32'(in_dest), 32'(NUM_PORTS));

    // One-hot port selects; an out-of-range dest decodes to all zeros.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_sel
        assign in_sel[gi]  = (in_dest == ADDR_W'(gi));
        assign hdr_sel[gi] = (hdr_dest == ADDR_W'(gi));
    end

    assign cur_empty = |(fifo_empty & hdr_sel);
    assign cur_full  = |(fifo_full & hdr_sel);
    assign soft_hit  = |(soft_rst & hdr_sel);

    router_parity_acc #(.DATA_W(DATA_W)) u_parity (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .load     (acc_load),
        .acc_en   (acc_xor),
        .din      (data_in),
        .cmp_val  (par_reg),
        .mismatch (par_mismatch)
    );

`ifdef ROUTER_LEN_CHECK_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_reg <= '0;
        end else if (cnt_inc) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign len_err = (cnt_reg != CNT_W'(field_len(32'(hdr_reg), ADDR_W)));
`else
    logic unused_cnt;
    assign unused_cnt = cnt_clr ^ cnt_inc;
    assign len_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DECODE_ADDRESS;
            hdr_reg   <= '0;
            par_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hdr_reg   <= hdr_next;
            par_reg   <= par_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hdr_next   = hdr_reg;
        par_next   = par_reg;
        err_next   = err_reg;
        busy       = 1'b0;
        wr_en      = '0;
        lfd_state  = 1'b0;
        data_out   = '0;
        acc_clear  = 1'b0;
        acc_load   = 1'b0;
        acc_xor    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        case (state_reg)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    hdr_next = data_in;
                    acc_load = 1'b1;
                    cnt_clr  = 1'b1;
                    if (!in_dest_ok)
                        state_next = DISCARD;
                    else if (|(fifo_empty & in_sel))
                        state_next = LOAD_FIRST_DATA;
                    else
                        state_next = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (cur_empty)
                    state_next = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                busy       = 1'b1;
                lfd_state  = 1'b1;
                wr_en      = hdr_sel;
                data_out   = hdr_reg;
                state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                data_out = data_in;
                if (cur_full) begin
                    // Stall the source; the held byte is written on return.
                    busy       = 1'b1;
                    state_next = FIFO_FULL_STATE;
                end else begin
                    wr_en = hdr_sel;
                    if (pkt_valid) begin
                        acc_xor = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        par_next   = data_in;
                        state_next = CHECK_PARITY;
                    end
                end
            end
            FIFO_FULL_STATE: begin
                busy = 1'b1;
                if (!cur_full)
                    state_next = LOAD_DATA;
            end
            CHECK_PARITY: begin
                busy       = 1'b1;
                err_next   = par_mismatch | len_err;
                state_next = DECODE_ADDRESS;
            end
            DISCARD: begin
                if (!pkt_valid)
                    state_next = DECODE_ADDRESS;
            end
            default: state_next = DECODE_ADDRESS;
        endcase

        // A flush of the target FIFO abandons the packet and drops this cycle's write.
        if (soft_hit && state_reg != DECODE_ADDRESS && state_reg != DISCARD) begin
            state_next = DISCARD;
            wr_en      = '0;
            lfd_state  = 1'b0;
            err_next   = err_reg;
            par_next   = par_reg;
            acc_xor    = 1'b0;
            acc_clear  = 1'b1;
            cnt_inc    = 1'b0;
        end
    end

    assign err = err_reg;

endmodule
